// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StTrap  = 2'd3
    } state_e;

    localparam logic [6:0]  OPCODE_BRANCH    = 7'b1100011;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and IMEM.
interface pc_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/pc_fetch_unit_pc_reg_adder.sv
// PC register with its increment adder and the alignment check on the next PC.
module pc_reg_adder
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en_i,
    input  logic [31:0] incremento_i,
    output logic [31:0] pc_o,
    output logic        next_misaligned_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Carry out is dropped: the PC wraps modulo 2^32.
    assign pc_d = pc_q + incremento_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load_en_i) begin
            pc_q <= pc_d;
        end
    end

    assign pc_o              = pc_q;
    assign next_misaligned_o = is_misaligned(pc_d);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, fetches over a req/ack bus, presents the instruction until
// execute retires it, then advances the PC. Misalignment or fetch timeout traps until reset.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_fetch_unit_if.master      imem,
    input  logic [31:0]          incremento_i,
    input  logic                 stall_i,
    output logic [31:0]          instruccion_o,
    output logic                 instr_valid_o,
    input  logic                 instr_done_i,
    output logic [31:0]          pc_o,
    output logic                 fetch_error_o,
    output logic [CNT_W-1:0]     instr_count_o
);

    localparam int unsigned          TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmoW-1:0]      TmoLast = TmoW'(TIMEOUT - 1);

    state_e            state_q;
    logic [31:0]       instr_q;
    logic              valid_q;
    logic              error_q;
    logic [CNT_W-1:0]  count_q;
    logic [TmoW-1:0]   tmo_q;

    logic [31:0]       pc;
    logic              next_misaligned;
    logic              retire;

    assign retire = (state_q == StExec) && instr_done_i;

    pc_reg_adder #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg_adder (
        .clk               (clk),
        .rst_n             (rst_n),
        .load_en_i         (retire),
        .incremento_i      (incremento_i),
        .pc_o              (pc),
        .next_misaligned_o (next_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            instr_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            count_q <= '0;
            tmo_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (is_misaligned(pc)) begin
                        state_q <= StTrap;
                        error_q <= 1'b1;
                    end else if (!stall_i) begin
                        state_q <= StFetch;
                        tmo_q   <= '0;
                    end
                end
                // Stall is deliberately ignored here: a request is never withdrawn.
                StFetch: begin
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_data;
                        valid_q <= 1'b1;
                        state_q <= StExec;
                    end else if (tmo_q == TmoLast) begin
                        state_q <= StTrap;
                        error_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StExec: begin
                    if (instr_done_i) begin
                        count_q <= count_q + 1'b1;
                        valid_q <= 1'b0;
                        if (next_misaligned) begin
                            state_q <= StTrap;
                            error_q <= 1'b1;
                        end else if (!stall_i) begin
                            state_q <= StFetch;
                            tmo_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StTrap: begin
                    valid_q <= 1'b0;
                    error_q <= 1'b1;
                end
                default: state_q <= StTrap;
            endcase
        end
    end

    // Request is decoded from state so it falls the instant reset asserts.
    assign imem.imem_req  = (state_q == StFetch);
    assign imem.imem_addr = pc;

    assign instruccion_o = instr_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc;
    assign fetch_error_o = error_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a zero/variable-wait instruction memory model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] incr;
    logic        stall;
    logic        done;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] pc;
    logic        ferr;
    logic [31:0] count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pc_m;
    logic [31:0] cnt_m;

    pc_fetch_unit_if imem ();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem),
        .incremento_i  (incr),
        .stall_i       (stall),
        .instruccion_o (instr),
        .instr_valid_o (valid),
        .instr_done_i  (done),
        .pc_o          (pc),
        .fetch_error_o (ferr),
        .instr_count_o (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for a request and checks its address.
    task automatic wait_req(input logic [31:0] exp_addr, input string tag);
        int n = 0;
        while (imem.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, {31'd0, imem.imem_req}, 32'd1);
        chk({tag, "_addr"}, imem.imem_addr, exp_addr);
    endtask

    task automatic fetch(input int delay, input logic [31:0] data, input logic [31:0] addr,
                         input string tag);
        wait_req(addr, tag);
        imem.imem_ack = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({tag, "_hold_req"}, {31'd0, imem.imem_req}, 32'd1);
            chk({tag, "_hold_addr"}, imem.imem_addr, addr);
        end
        imem.imem_ack  = 1'b1;
        imem.imem_data = data;
        exp_q.push_back(data);
        @(negedge clk);
        imem.imem_ack  = 1'b0;
        imem.imem_data = 32'hdead_beef;
        chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
        chk({tag, "_instr"}, instr, exp_q.pop_front());
        chk({tag, "_req_drop"}, {31'd0, imem.imem_req}, 32'd0);
    endtask

    task automatic retire(input logic [31:0] inc, input logic s, input string tag);
        done  = 1'b1;
        incr  = inc;
        stall = s;
        @(negedge clk);
        done  = 1'b0;
        incr  = 32'h0;
        pc_m  = pc_m + inc;
        cnt_m = cnt_m + 1;
        chk({tag, "_pc"}, pc, pc_m);
        chk({tag, "_cnt"}, count, cnt_m);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b1;
        done  = 1'b0;
        incr  = 32'h0;
        imem.imem_ack  = 1'b0;
        imem.imem_data = 32'h0;
        pc_m  = 32'h0;
        cnt_m = 32'h0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("rst_err", {31'd0, ferr}, 32'd0);
        chk("rst_cnt", count, 32'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        chk("first_req_imm", {31'd0, imem.imem_req}, 32'd1);

        // Three sequential instructions, last one retired under stall.
        fetch(0, 32'h0050_0093, 32'h0, "f0");
        retire(32'd4, 1'b0, "r0");
        fetch(0, 32'h0040_0113, 32'h4, "f1");
        retire(32'd4, 1'b0, "r1");
        fetch(0, 32'h0020_81b3, 32'h8, "f2");
        retire(32'd4, 1'b1, "r2");
        chk("seq_pc12", pc, 32'd12);
        chk("seq_cnt3", count, 32'd3);
        @(negedge clk);
        chk("stall_noreq0", {31'd0, imem.imem_req}, 32'd0);
        @(negedge clk);
        chk("stall_noreq1", {31'd0, imem.imem_req}, 32'd0);
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_req", {31'd0, imem.imem_req}, 32'd1);
        chk("unstall_addr", imem.imem_addr, 32'd12);

        // Branch backwards from 0x100.
        fetch(0, 32'h0000_006f, 32'd12, "f3");
        retire(32'h0000_00f4, 1'b0, "r3");
        fetch(0, 32'hfe00_0ce3, 32'h100, "fbr");
        retire(32'hffff_fff8, 1'b0, "rbr");

        // Ack delayed by five cycles: no trap.
        fetch(5, 32'h0000_0013, 32'hf8, "slow");
        chk("slow_noerr", {31'd0, ferr}, 32'd0);
        retire(32'd4, 1'b0, "rslow");

        // No ack at all: trap after TIMEOUT cycles of request.
        wait_req(32'hfc, "tmo");
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("tmo_req_held", {31'd0, imem.imem_req}, 32'd1);
            chk("tmo_noerr", {31'd0, ferr}, 32'd0);
        end
        @(negedge clk);
        chk("tmo_err", {31'd0, ferr}, 32'd1);
        chk("tmo_req_off", {31'd0, imem.imem_req}, 32'd0);
        chk("tmo_pc", pc, 32'hfc);

        // Reset clears the trap, then a misaligned increment traps.
        rst_n = 1'b0;
        #1;
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_err", {31'd0, ferr}, 32'd0);
        pc_m  = 32'h0;
        cnt_m = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(0, 32'h0000_0013, 32'h0, "f4");
        retire(32'd2, 1'b0, "rmis");
        chk("mis_err", {31'd0, ferr}, 32'd1);
        chk("mis_pc", pc, 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mis_noreq", {31'd0, imem.imem_req}, 32'd0);
            chk("mis_pc_frozen", pc, 32'd2);
        end

        rst_n = 1'b0;
        #1;
        chk("rst3_pc", pc, 32'h0);
        chk("rst3_err", {31'd0, ferr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wait_req(32'h0, "midf");
        // Reset during FETCH drops the request at once; a late ack is ignored.
        rst_n = 1'b0;
        #1;
        chk("midf_req_drop", {31'd0, imem.imem_req}, 32'd0);
        stall          = 1'b1;
        imem.imem_ack  = 1'b1;
        imem.imem_data = 32'h1234_5678;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem.imem_ack = 1'b0;
        chk("late_ack_valid", {31'd0, valid}, 32'd0);
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_cnt", count, 32'h0);
        chk("late_ack_req", {31'd0, imem.imem_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage; consumes the next-PC increment from the branch/next-PC mux (4 or the branch offset).
- Holds the PC, issues a req/ack fetch to instruction memory, latches the returned word and presents it as the current instruction (which also feeds the mux) until execution signals completion.
- Then advances PC by the increment; traps on misaligned PC or fetch timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles in FETCH without IMEM_Ack before trap (must be >= 1).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Incremento  in  32  PC increment from next-PC mux (4 or shifted branch offset, two's complement).
- Stall  in  1  hold off new fetches while high.
- IMEM_Req  out  1  fetch request to instruction memory.
- IMEM_Addr  out  32  fetch address (= PC).
- IMEM_Ack  in  1  memory accepted request; IMEM_Data valid this cycle.
- IMEM_Data  in  32  fetched instruction word.
- Instruccion  out  32  latched current instruction (to decode and next-PC mux).
- Instr_Valid  out  1  Instruccion holds a live instruction.
- Instr_Done  in  1  execute stage finished current instruction; commit PC update.
- PC  out  32  current program counter.
- Fetch_Error  out  1  sticky trap flag.
- Instr_Count  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC; Instruccion=0; Instr_Valid=0; IMEM_Req=0; Fetch_Error=0; Instr_Count=0; timeout counter=0; state=IDLE. Outputs take reset values immediately; on release, operation starts at the next rising edge.
- States: IDLE, FETCH, EXEC, TRAP.
- IDLE:
  - Stall=0 -> FETCH next cycle; Stall=1 -> stay.
  - If PC[1:0]!=0 -> TRAP instead.
- FETCH:
  - IMEM_Req=1 (combinational from state); IMEM_Addr=PC, held stable until Ack.
  - IMEM_Ack=1 same cycle: Instruccion<=IMEM_Data; Instr_Valid<=1; -> EXEC. Zero-wait memory therefore gives Instr_Valid one cycle after FETCH entry.
  - Stall is ignored once in FETCH; the request is never withdrawn.
  - Timeout counter increments each FETCH cycle without Ack. At count == TIMEOUT-1 with no Ack -> TRAP. Counter clears on entering FETCH.
- EXEC:
  - Instr_Valid=1 and Instruccion stable.
  - On Instr_Done=1: sample Incremento in that same cycle. PC<=PC+Incremento (32-bit wrap, carry discarded); Instr_Count<=Instr_Count+1 (wraps); Instr_Valid<=0.
  - Next state after Done: next PC[1:0]!=0 -> TRAP; else Stall=0 -> FETCH; else -> IDLE.
  - Instr_Done outside EXEC is ignored.
- TRAP: Fetch_Error=1, IMEM_Req=0, Instr_Valid=0, PC frozen at offending value; exit only via reset.
- IMEM_Ack while IMEM_Req=0 is ignored.
- Reset mid-fetch: IMEM_Req drops asynchronously; a late Ack after reset is ignored.
- Simultaneous Instr_Done and Stall in EXEC: PC update happens, then IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE/FETCH/EXEC/TRAP), OPCODE_BRANCH 7'b1100011, PC_STEP 32'd4, RESET_PC default.
- One natural sub-module: pc_reg_adder. It holds the PC register, the adder and the alignment check, with inputs load_en and incremento and outputs pc and next_misaligned.
- FSM, timeout counter and instruction latch stay in pc_fetch_unit.

Test Plan:
- Reset then Stall=0, zero-wait memory returning 32'h00500093 -> IMEM_Req at addr 0; Instr_Valid=1 next cycle; Instruccion=32'h00500093.
- Three sequential instructions, Incremento=4, Done one cycle after each Valid -> fetch addrs 0,4,8; PC=12; Instr_Count=3.
- Branch: PC=0x100, Incremento=32'hFFFF_FFF8 at Done -> PC=0xF8; next IMEM_Addr=0xF8.
- Memory delays Ack 5 cycles, TIMEOUT=16 -> IMEM_Req and IMEM_Addr held 6 cycles; no trap. No Ack for 16 cycles -> Fetch_Error=1, IMEM_Req=0.
- Incremento=2 at Done from PC=0 -> TRAP, PC=2, Fetch_Error=1, no further requests. Reset clears the trap: PC=0, Fetch_Error=0.
- Stall=1 with Done in EXEC -> PC updated, state IDLE, no Req. Stall released -> Req next cycle. Reset asserted during FETCH -> IMEM_Req=0 immediately.
